// File: rtl/jtpang_pkg.sv
// Shared constants and FSM encoding for the object-RAM DMA engine.
package jtpang_pkg;

  localparam int unsigned DefAw  = 9;
  localparam int unsigned DefLen = 512;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StXfer,
    StRel
  } dma_state_e;

endpackage

// File: rtl/jtpang_dma.sv
// Copies LEN bytes of object RAM into the object buffer while holding the CPU bus,
// one byte per granted cen step.
module jtpang_dma
  import jtpang_pkg::*;
#(
  parameter int unsigned AW  = DefAw,
  parameter int unsigned LEN = DefLen
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          dma_go,
  output logic          busrq,
  input  logic          busak_n,
  output logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_din,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LastAddr = AW'(LEN - 1);

  dma_state_e    state_q;
  logic          pending_q;
  logic          busrq_q;
  logic          busy_q;
  logic          done_q;
  logic          buf_we_q;
  logic [AW-1:0] dma_addr_q;
  logic [AW-1:0] buf_addr_q;
  logic [7:0]    buf_din_q;
  logic          step;

  assign step = cen & ~busak_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pending_q  <= 1'b0;
      busrq_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      buf_we_q   <= 1'b0;
      dma_addr_q <= '0;
      buf_addr_q <= '0;
      buf_din_q  <= '0;
    end else begin
      buf_we_q <= 1'b0;
      done_q   <= 1'b0;
      if (dma_go) pending_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          // A request coinciding with the pickup is merged into this transfer.
          if (pending_q) begin
            state_q    <= StReq;
            busrq_q    <= 1'b1;
            busy_q     <= 1'b1;
            pending_q  <= 1'b0;
            dma_addr_q <= '0;
          end
        end
        StReq: begin
          if (step) state_q <= StXfer;
        end
        StXfer: begin
          if (step) begin
            buf_we_q   <= 1'b1;
            buf_addr_q <= dma_addr_q;
            buf_din_q  <= dma_din;
            if (dma_addr_q == LastAddr) begin
              state_q    <= StRel;
              busrq_q    <= 1'b0;
              dma_addr_q <= '0;
            end else begin
              dma_addr_q <= dma_addr_q + AW'(1);
            end
          end
        end
        StRel: begin
          // Bus release is watched every clk, independent of cen.
          if (busak_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busrq    = busrq_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign buf_we   = buf_we_q;
  assign dma_addr = dma_addr_q;
  assign buf_addr = buf_addr_q;
  assign buf_din  = buf_din_q;

endmodule

// File: tb/tb_jtpang_dma.sv
// Randomized bench for jtpang_dma: a CPU/RAM environment plus a transfer-level model.
module tb_jtpang_dma;

  localparam int unsigned Len    = 512;
  localparam int unsigned Aw     = 9;
  localparam int          GapLen = 5;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          cen     = 1'b0;
  logic          dma_go  = 1'b0;
  logic          busak_n = 1'b1;
  logic          busrq, buf_we, busy, done;
  logic [Aw-1:0] dma_addr, buf_addr;
  logic [7:0]    dma_din = 8'd0;
  logic [7:0]    buf_din;

  logic       dma_go_s  = 1'b0;
  logic       busak_n_s = 1'b1;
  logic       busrq_s, buf_we_s, busy_s, done_s;
  logic [1:0] dma_addr_s, buf_addr_s;
  logic [7:0] dma_din_s = 8'd0;
  logic [7:0] buf_din_s;

  logic [7:0] ram [Len];

  int n_tests = 0;
  int n_fail  = 0;

  int   cyc = 0;
  int   done_cnt = 0, bad_we = 0, bad_rq = 0, gap_writes = 0;
  int   gap_at = -1, gap_left = 0, rel_left = 0, ack_cnt = 0;
  bit   gap_seen = 1'b0;
  int   t_rq_fall = 0, t_done = 0;
  logic pc_cen = 1'b0, pc_bk = 1'b1, prev_busrq = 1'b0;
  int   wa_q[$];
  int   wd_q[$];

  jtpang_dma #(.AW(Aw), .LEN(Len)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .dma_go   (dma_go),
    .busrq    (busrq),
    .busak_n  (busak_n),
    .dma_addr (dma_addr),
    .dma_din  (dma_din),
    .buf_we   (buf_we),
    .buf_addr (buf_addr),
    .buf_din  (buf_din),
    .busy     (busy),
    .done     (done)
  );

  jtpang_dma #(.AW(2), .LEN(4)) u_short (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .dma_go   (dma_go_s),
    .busrq    (busrq_s),
    .busak_n  (busak_n_s),
    .dma_addr (dma_addr_s),
    .dma_din  (dma_din_s),
    .buf_we   (buf_we_s),
    .buf_addr (buf_addr_s),
    .buf_din  (buf_din_s),
    .busy     (busy_s),
    .done     (done_s)
  );

  always #5 clk = ~clk;

  // Synchronous RAM read and a record of what the DUT saw at each edge.
  always @(posedge clk) begin
    pc_cen    <= cen;
    pc_bk     <= busak_n;
    dma_din   <= ram[dma_addr];
    dma_din_s <= ram[dma_addr_s];
  end

  // cen: one clk high, then 1..3 clk low.
  initial begin
    forever begin
      @(negedge clk) cen = 1'b1;
      @(negedge clk) cen = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  end

  // Write monitor and CPU bus-grant model.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (done) begin
        done_cnt++;
        t_done = cyc;
      end
      if (prev_busrq && !busrq) t_rq_fall = cyc;
      prev_busrq = busrq;
      if (buf_we) begin
        wa_q.push_back(int'(buf_addr));
        wd_q.push_back(int'(buf_din));
        if (!(pc_cen && !pc_bk)) bad_we++;
        if (busrq !== (int'(buf_addr) != int'(Len) - 1)) bad_rq++;
        if (gap_left > 0) gap_writes++;
      end
      if (gap_left > 0) begin
        if (pc_cen) gap_left--;
        busak_n = (gap_left == 0) ? 1'b0 : 1'b1;
      end else if (busrq) begin
        if (busak_n) begin
          if (pc_cen) ack_cnt++;
          if (ack_cnt >= 2) begin
            busak_n = 1'b0;
            ack_cnt = 0;
          end
        end
      end else begin
        ack_cnt = 0;
        if (!busak_n) begin
          if (rel_left > 0) rel_left--;
          else busak_n = 1'b1;
        end
      end
      if (buf_we && int'(buf_addr) == gap_at - 1) begin
        gap_left = GapLen;
        gap_seen = 1'b1;
        busak_n  = 1'b1;
      end
      busak_n_s = ~busrq_s;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_go();
    dma_go = 1'b1;
    tick();
    dma_go = 1'b0;
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0; bad_we = 0; bad_rq = 0; gap_writes = 0;
    gap_at = -1; gap_left = 0; rel_left = 0; gap_seen = 1'b0;
    t_rq_fall = 0; t_done = 0;
    foreach (ram[i]) ram[i] = 8'($urandom);
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (done_cnt >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Expected write stream: consecutive transfers each writing addr 0..Len-1 with RAM data.
  function automatic int model_errs(input int first, input int n);
    int e;
    int a;
    e = 0;
    if (wa_q.size() < first + n) return n;
    for (int i = 0; i < n; i++) begin
      a = i % int'(Len);
      if (wa_q[first+i] != a || wd_q[first+i] != int'(ram[a])) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busrq, buf_we, done, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000", {busrq, buf_we, done, busy});
    end
    n_tests++;
    if ({dma_addr, buf_addr, buf_din} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%h want 0/0/0", dma_addr, buf_addr, buf_din);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    n_tests++;
    if (busy !== 1'b0 || busrq !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b busrq=%b want 0 0", busy, busrq);
    end
  endtask

  task automatic test_basic();
    bit ok;
    repeat (10) tick();
    clear_mon();
    pulse_go();
    n_tests++;
    if (busrq !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_1clk: busrq=%b want 0", busrq);
    end
    tick();
    n_tests++;
    if (busrq !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_2clk: busrq=%b busy=%b want 1 1", busrq, busy);
    end
    wait_done(1, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_done_timeout: done_cnt=%0d want 1", done_cnt);
    end
    repeat (20) tick();
    n_tests++;
    if (wa_q.size() != int'(Len) || model_errs(0, int'(Len)) != 0) begin
      n_fail++;
      $display("FAIL basic_writes: count=%0d errs=%0d want %0d 0", wa_q.size(),
               model_errs(0, int'(Len)), Len);
    end
    n_tests++;
    if (done_cnt != 1 || bad_we != 0 || bad_rq != 0) begin
      n_fail++;
      $display("FAIL basic_protocol: done=%0d bad_we=%0d bad_rq=%0d want 1 0 0",
               done_cnt, bad_we, bad_rq);
    end
    n_tests++;
    if (t_done - t_rq_fall != 1 || dma_addr !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release: done_delay=%0d addr=%0d busy=%b want 1 0 0",
               t_done - t_rq_fall, dma_addr, busy);
    end
  endtask

  task automatic test_grant_loss();
    bit ok;
    repeat (10) tick();
    clear_mon();
    gap_at = 100;
    pulse_go();
    wait_done(1, ok);
    repeat (20) tick();
    n_tests++;
    if (!ok || !gap_seen) begin
      n_fail++;
      $display("FAIL gap_run: done_ok=%0d gap_seen=%0d want 1 1", ok, gap_seen);
    end
    n_tests++;
    if (gap_writes != 0 || bad_we != 0) begin
      n_fail++;
      $display("FAIL gap_no_write: gap_writes=%0d bad_we=%0d want 0 0", gap_writes, bad_we);
    end
    n_tests++;
    if (wa_q.size() != int'(Len) || model_errs(0, int'(Len)) != 0) begin
      n_fail++;
      $display("FAIL gap_writes: count=%0d errs=%0d want %0d 0", wa_q.size(),
               model_errs(0, int'(Len)), Len);
    end
  endtask

  task automatic test_retrigger();
    bit ok;
    repeat (10) tick();
    clear_mon();
    pulse_go();
    for (int i = 0; i < 5000 && wa_q.size() < 50; i++) tick();
    pulse_go();
    tick();
    pulse_go();
    repeat (3) tick();
    pulse_go();
    wait_done(2, ok);
    repeat (300) tick();
    n_tests++;
    if (!ok || done_cnt != 2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL retrig_done: ok=%0d done=%0d busy=%b want 1 2 0", ok, done_cnt, busy);
    end
    n_tests++;
    if (wa_q.size() != 2 * int'(Len) || model_errs(0, 2 * int'(Len)) != 0) begin
      n_fail++;
      $display("FAIL retrig_writes: count=%0d errs=%0d want %0d 0", wa_q.size(),
               model_errs(0, 2 * int'(Len)), 2 * Len);
    end
  endtask

  task automatic test_rel_hold();
    bit ok;
    repeat (10) tick();
    clear_mon();
    rel_left = 20;
    pulse_go();
    wait_done(1, ok);
    repeat (20) tick();
    n_tests++;
    if (!ok || done_cnt != 1) begin
      n_fail++;
      $display("FAIL rel_done: ok=%0d done=%0d want 1 1", ok, done_cnt);
    end
    n_tests++;
    if (t_done - t_rq_fall != 21) begin
      n_fail++;
      $display("FAIL rel_hold: done %0d clk after busrq fall, want 21", t_done - t_rq_fall);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    repeat (10) tick();
    clear_mon();
    pulse_go();
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (wa_q.size() >= 300) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (!ok || busrq !== 1'b0 || buf_we !== 1'b0 || busy !== 1'b0 || dma_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_async: ok=%0d busrq=%b we=%b busy=%b addr=%0d want 1 0 0 0 0",
               ok, busrq, buf_we, busy, dma_addr);
    end
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (300) tick();
    n_tests++;
    if (wa_q.size() != 300 || done_cnt != 0 || busrq !== 1'b0 || model_errs(0, 300) != 0) begin
      n_fail++;
      $display("FAIL reset_abandon: writes=%0d done=%0d busrq=%b want 300 0 0",
               wa_q.size(), done_cnt, busrq);
    end
    pulse_go();
    wait_done(1, ok);
    repeat (20) tick();
    n_tests++;
    if (!ok || wa_q.size() != 300 + int'(Len) || model_errs(300, int'(Len)) != 0) begin
      n_fail++;
      $display("FAIL reset_restart: ok=%0d writes=%0d want 1 %0d", ok, wa_q.size(), 300 + Len);
    end
  endtask

  task automatic test_short();
    int sa[$];
    int sd[$];
    int sdone;
    int errs;
    sdone = 0;
    errs  = 0;
    repeat (5) tick();
    dma_go_s = 1'b1;
    tick();
    dma_go_s = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (buf_we_s) begin
        sa.push_back(int'(buf_addr_s));
        sd.push_back(int'(buf_din_s));
      end
      if (done_s) sdone++;
    end
    foreach (sa[i]) if (sa[i] != i || sd[i] != int'(ram[i])) errs++;
    n_tests++;
    if (sa.size() != 4 || errs != 0) begin
      n_fail++;
      $display("FAIL short_writes: count=%0d errs=%0d want 4 0", sa.size(), errs);
    end
    n_tests++;
    if (sdone != 1 || dma_addr_s !== 2'd0 || busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL short_end: done=%0d addr=%0d busy=%b want 1 0 0", sdone, dma_addr_s, busy_s);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_grant_loss();
    test_retrigger();
    test_rel_hold();
    test_reset_mid();
    test_short();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
